// File: rtl/fp_norm_lzc_pkg.sv
// Shared constants and types for the FP add/sub normalisation front-end.
package fp_norm_lzc_pkg;

  localparam int unsigned EXP_MAX = 255;

  localparam int unsigned FLG_ZERO = 0;
  localparam int unsigned FLG_OVF  = 1;
  localparam int unsigned FLG_UNF  = 2;
  localparam int unsigned FLG_W    = 3;

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_CARRY,
    CLS_ZERO,
    CLS_DENORM
  } norm_cls_e;

endpackage

// File: rtl/fp_lzc24.sv
// Combinational 24-bit leading-zero counter; all-zero input yields 24.
module fp_lzc24 (
  input  logic [23:0] data,
  output logic [4:0]  lz
);

  logic [5:0] nib_any;
  logic [1:0] nib_cnt [6];
  logic [3:0] nib;

  always_comb begin
    nib = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      nib        = data[4*i +: 4];
      nib_any[i] = |nib;
      nib_cnt[i] = nib[3] ? 2'd0 : nib[2] ? 2'd1 : nib[1] ? 2'd2 : 2'd3;
    end
  end

  // Walk nibbles LSB to MSB so the most significant non-zero nibble wins.
  always_comb begin
    lz = 5'd24;
    for (int unsigned i = 0; i < 6; i++) begin
      if (nib_any[i]) lz = 5'((5 - i) * 4) + {3'b000, nib_cnt[i]};
    end
  end

endmodule

// File: rtl/fp_norm_lzc.sv
// Normalisation front-end: two-stage valid/ready pipeline producing shift count,
// adjusted exponent and pre-shift mantissa for the left barrel shifter.
module fp_norm_lzc
  import fp_norm_lzc_pkg::*;
#(
  parameter int unsigned MANT_W = 25,
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned SH_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W-1:0] mant_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mant_out,
  output logic [SH_W-1:0]   shift_amt,
  output logic              guard_out,
  output logic              zero_out,
  output logic              ovf_out,
  output logic              unf_out
);

  localparam logic [EXP_W:0] EXP_TOP = (EXP_W+1)'(EXP_MAX);

  logic              s1_valid;
  logic              s1_sign;
  logic [EXP_W-1:0]  s1_exp;
  logic [MANT_W-1:0] s1_mant;
  logic              s1_adv;
  logic              s2_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= sign_in;
        s1_exp  <= exp_in;
        s1_mant <= mant_in;
      end
    end
  end

  logic [SH_W-1:0]   lz;
  logic [EXP_W:0]    exp_x;
  logic [EXP_W:0]    lz_x;
  logic [EXP_W:0]    exp_nxt;
  logic [MANT_W-1:0] n_mant;
  logic [SH_W-1:0]   n_sh;
  logic              n_guard;
  logic [FLG_W-1:0]  n_flags;
  norm_cls_e         cls;

  fp_lzc24 u_lzc (
    .data (s1_mant[MANT_W-2:0]),
    .lz   (lz)
  );

  always_comb begin
    exp_x   = {1'b0, s1_exp};
    lz_x    = (EXP_W+1)'(lz);
    exp_nxt = '0;
    n_mant  = '0;
    n_sh    = '0;
    n_guard = 1'b0;
    n_flags = '0;

    if (s1_mant[MANT_W-1])   cls = CLS_CARRY;
    else if (s1_mant == '0)  cls = CLS_ZERO;
    else if (exp_x > lz_x)   cls = CLS_NORM;
    else                     cls = CLS_DENORM;

    case (cls)
      CLS_CARRY: begin
        n_guard = s1_mant[0];
        exp_nxt = exp_x + 1'b1;
        // exp_in >= EXP_MAX-1 is the same test as exp_in+1 >= EXP_MAX in the widened domain.
        if (exp_nxt >= EXP_TOP) begin
          exp_nxt          = EXP_TOP;
          n_flags[FLG_OVF] = 1'b1;
        end else begin
          n_mant = {1'b0, s1_mant[MANT_W-1:1]};
        end
      end
      CLS_ZERO: n_flags[FLG_ZERO] = 1'b1;
      CLS_NORM: begin
        n_mant  = s1_mant;
        n_sh    = lz;
        exp_nxt = exp_x - lz_x;
      end
      CLS_DENORM: begin
        n_mant           = s1_mant;
        n_sh             = (exp_x == '0) ? '0 : SH_W'(exp_x - 1'b1);
        n_flags[FLG_UNF] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sign_out  <= 1'b0;
      exp_out   <= '0;
      mant_out  <= '0;
      shift_amt <= '0;
      guard_out <= 1'b0;
      zero_out  <= 1'b0;
      ovf_out   <= 1'b0;
      unf_out   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sign_out  <= s1_sign;
        exp_out   <= exp_nxt[EXP_W-1:0];
        mant_out  <= n_mant;
        shift_amt <= n_sh;
        guard_out <= n_guard;
        zero_out  <= n_flags[FLG_ZERO];
        ovf_out   <= n_flags[FLG_OVF];
        unf_out   <= n_flags[FLG_UNF];
      end
    end
  end

endmodule
